// File: rtl/uart_rx_frame_ctrl.sv
// Frames bytes popped from the UART RX FIFO into SOF/LEN/payload/CHK packets.
// Streams payload with valid/ready and pulses a per-frame status outcome.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd,
    output logic [7:0] pl_data,
    output logic       pl_valid,
    input  logic       pl_ready,
    output logic       pl_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0] MAX_B = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHECK
    } state_t;

    state_t        state, state_nx;
    logic [7:0]    len, len_nx;
    logic [7:0]    cnt, cnt_nx;
    logic [7:0]    chk, chk_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          ok_nx, err_nx;
    logic [2:0]    code_nx;
    logic          pop;
    logic          stall;
    logic          at_last;

    assign at_last = (cnt == len - 8'd1);
    assign pop     = !fifo_empty && enable && (state != PAYLOAD || pl_ready);
    assign stall   = (state == PAYLOAD) && !fifo_empty && !pl_ready;

    assign fifo_rd  = pop;
    assign pl_data  = fifo_dout;
    assign pl_valid = (state == PAYLOAD) && !fifo_empty && enable;
    assign pl_last  = pl_valid && at_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            len       <= '0;
            cnt       <= '0;
            chk       <= '0;
            timer     <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
        end else begin
            state     <= state_nx;
            len       <= len_nx;
            cnt       <= cnt_nx;
            chk       <= chk_nx;
            timer     <= timer_nx;
            frame_ok  <= ok_nx;
            frame_err <= err_nx;
            err_code  <= code_nx;
        end
    end

    always_comb begin
        state_nx = state;
        len_nx   = len;
        cnt_nx   = cnt;
        chk_nx   = chk;
        timer_nx = timer;
        ok_nx    = 1'b0;
        err_nx   = 1'b0;
        code_nx  = err_code;

        if (state != HUNT && !enable) begin
            // frame abandoned because parsing was switched off mid-frame
            err_nx   = 1'b1;
            code_nx  = 3'd4;
            state_nx = HUNT;
            timer_nx = '0;
        end else if (pop) begin
            timer_nx = '0;
            case (state)
                HUNT: begin
                    if (fifo_dout == SOF) state_nx = LEN;
                end
                LEN: begin
                    if (fifo_dout != 8'd0 && fifo_dout <= MAX_B) begin
                        len_nx   = fifo_dout;
                        chk_nx   = fifo_dout;
                        cnt_nx   = '0;
                        state_nx = PAYLOAD;
                    end else begin
                        err_nx   = 1'b1;
                        code_nx  = 3'd1;
                        state_nx = HUNT;
                    end
                end
                PAYLOAD: begin
                    chk_nx = chk ^ fifo_dout;
                    cnt_nx = cnt + 8'd1;
                    if (at_last) state_nx = CHECK;
                end
                CHECK: begin
                    if (fifo_dout == chk) begin
                        ok_nx   = 1'b1;
                        code_nx = 3'd0;
                    end else begin
                        err_nx  = 1'b1;
                        code_nx = 3'd2;
                    end
                    state_nx = HUNT;
                end
                default: state_nx = HUNT;
            endcase
        end else if (state == HUNT) begin
            timer_nx = '0;
        end else if (stall) begin
            // downstream back-pressure holds the timer
            timer_nx = timer;
        end else if (timer == T_LAST) begin
            err_nx   = 1'b1;
            code_nx  = 3'd3;
            state_nx = HUNT;
            timer_nx = '0;
        end else begin
            timer_nx = timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a queue-backed FWFT FIFO model.
// Expected streams, status codes and pulse timing are hand-computed.
module tb_uart_rx_frame_ctrl;

    localparam int TO = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       pl_last;
    logic       frame_ok;
    logic       frame_err;
    logic [2:0] err_code;

    uart_rx_frame_ctrl #(
        .SOF    (8'hA5),
        .MAX_LEN(16),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd   (fifo_rd),
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .pl_last   (pl_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         cycle = 0;
    int         t0;
    logic [7:0] q[$];
    logic [8:0] got[$];
    int         nstat;
    int         nboth;
    int         stat_cyc;
    int         bad_rd;
    logic       s_ok;
    logic [2:0] s_code;

    task automatic check(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty = (q.size() == 0);
        fifo_dout  = fifo_empty ? 8'h00 : q[0];
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        refresh();
    endtask

    task automatic mon_clear();
        got.delete();
        nstat  = 0;
        nboth  = 0;
        bad_rd = 0;
        s_ok   = 1'b0;
        s_code = 3'd7;
        t0     = cycle;
    endtask

    task automatic cyc();
        logic rd;
        #1;
        rd = fifo_rd;
        if (!enable && (fifo_rd || pl_valid)) bad_rd++;
        if (pl_valid && pl_ready) got.push_back({pl_last, pl_data});
        if (frame_ok || frame_err) begin
            nstat++;
            s_ok     = frame_ok;
            s_code   = err_code;
            stat_cyc = cycle - t0;
        end
        if (frame_ok && frame_err) nboth++;
        @(posedge clk);
        cycle++;
        if (rd) void'(q.pop_front());
        #1;
        refresh();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic push_std(input logic [7:0] c);
        push(8'hA5); push(8'h03); push(8'h11);
        push(8'h22); push(8'h33); push(c);
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        pl_ready = 1'b1;
        refresh();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_ok", frame_ok, 0);
        check("rst_err", frame_err, 0);
        check("rst_code", err_code, 0);
        check("rst_rd", fifo_rd, 0);
        reset = 1'b0;

        mon_clear();
        push_std(8'h03);
        run(10);
        check("t1_nstat", nstat, 1);
        check("t1_ok", s_ok, 1);
        check("t1_code", s_code, 0);
        check("t1_when", stat_cyc, 6);
        check("t1_n", got.size(), 3);
        if (got.size() == 3) begin
            check("t1_b0", got[0], 9'h011);
            check("t1_b1", got[1], 9'h022);
            check("t1_b2", got[2], 9'h133);
        end

        mon_clear();
        push_std(8'h04);
        run(10);
        check("t2_n", got.size(), 3);
        check("t2_nstat", nstat, 1);
        check("t2_ok", s_ok, 0);
        check("t2_code", s_code, 2);
        check("t2_ok_rst", frame_ok, 0);

        mon_clear();
        push(8'h00); push(8'h7E); push(8'hA5); push(8'h00);
        run(8);
        check("t3_n", got.size(), 0);
        check("t3_nstat", nstat, 1);
        check("t3_code", s_code, 1);
        check("t3_when", stat_cyc, 4);
        mon_clear();
        push(8'hA5); push(8'h11);
        run(6);
        check("t3_max_st", nstat, 1);
        check("t3_max_cd", s_code, 1);

        mon_clear();
        push(8'hA5); push(8'h10);
        for (int i = 0; i < 16; i++) push(8'(i));
        push(8'h10);
        run(24);
        check("t3b_n", got.size(), 16);
        check("t3b_ok", s_ok, 1);
        check("t3b_code", s_code, 0);
        if (got.size() == 16) check("t3b_last", got[15], 9'h10F);

        mon_clear();
        push(8'hA5); push(8'h01); push(8'h5A); push(8'h5B);
        run(6);
        check("t3c_n", got.size(), 1);
        if (got.size() == 1) check("t3c_b", got[0], 9'h15A);
        check("t3c_ok", s_ok, 1);

        mon_clear();
        push(8'hA5); push(8'h02); push(8'hA5); push(8'hA5); push(8'h02);
        run(8);
        check("t3d_n", got.size(), 2);
        check("t3d_st", nstat, 1);
        check("t3d_ok", s_ok, 1);

        mon_clear();
        push(8'hA5); push(8'h02); push(8'hAA);
        run(TO + 6);
        check("t4_nstat", nstat, 1);
        check("t4_code", s_code, 3);
        check("t4_when", stat_cyc, TO + 3);

        mon_clear();
        pl_ready = 1'b0;
        push(8'hA5); push(8'h02); push(8'h01); push(8'h02); push(8'h01);
        run(3 * TO);
        check("t4s_nstat", nstat, 0);
        check("t4s_q", q.size(), 3);
        pl_ready = 1'b1;
        run(6);
        check("t4s_n", got.size(), 2);
        if (got.size() == 2) check("t4s_b1", got[1], 9'h102);
        check("t4s_ok", s_ok, 1);
        check("t4s_st", nstat, 1);

        mon_clear();
        push_std(8'h03);
        run(2);
        enable = 1'b0;
        run(6);
        check("t5_nstat", nstat, 1);
        check("t5_code", s_code, 4);
        check("t5_rd", bad_rd, 0);
        check("t5_q", q.size(), 4);
        enable = 1'b1;
        mon_clear();
        run(8);
        check("t5_drop_st", nstat, 0);
        check("t5_drop_n", got.size(), 0);

        mon_clear();
        push_std(8'h03);
        run(3);
        q.delete();
        refresh();
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        check("t5r_ok", frame_ok, 0);
        check("t5r_err", frame_err, 0);
        check("t5r_code", err_code, 0);
        check("t5r_valid", pl_valid, 0);
        run(4);
        check("t5r_nstat", nstat, 0);
        mon_clear();
        push(8'hA5); push(8'h01); push(8'h5A); push(8'h5B);
        run(6);
        check("t5r_ok2", s_ok, 1);
        check("t5r_st2", nstat, 1);

        check("never_both", nboth, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
